// File: rtl/dcache_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dcache_access_ctrl_pkg
// Brief   : Shared access codes, width constants, FSM state encodings and
//           decode helpers for the MEM-stage data-access controller.
// Revision: 1.0 - initial release
// ============================================================================
package dcache_access_ctrl_pkg;

    localparam int c_data_w = 32;

    // Access width codes, in bytes
    localparam logic [2:0] c_w_byte = 3'd1;
    localparam logic [2:0] c_w_half = 3'd2;
    localparam logic [2:0] c_w_word = 3'd4;

    // Controller states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Access kind derived from the decoder's ren/wen pair
    typedef enum logic [1:0] {
        MEM_NONE    = 2'd0,
        MEM_LOAD    = 2'd1,
        MEM_STORE   = 2'd2,
        MEM_ILLEGAL = 2'd3
    } mem_op_e;

    function automatic mem_op_e mem_op(input logic ren, input logic wen);
        return mem_op_e'({wen, ren});
    endfunction

    function automatic logic width_ok(input logic [2:0] w);
        return (w == c_w_byte) || (w == c_w_half) || (w == c_w_word);
    endfunction

    // Halves need an even address, words a 4-byte aligned address
    function automatic logic is_aligned(input logic [2:0] w, input logic [1:0] off);
        return !(((w == c_w_half) && off[0]) || ((w == c_w_word) && (off != 2'b00)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : dcache_access_ctrl_if
// Brief   : Single-port data-memory bus between the access controller
//           (master) and the memory (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface dcache_access_ctrl_if;
    import dcache_access_ctrl_pkg::*;

    logic                req;
    logic                we;
    logic [c_data_w-1:0] addr;
    logic [c_data_w-1:0] wdata;
    logic [3:0]          wstrb;
    logic                gnt;
    logic                rvalid;
    logic [c_data_w-1:0] rdata;

    modport master (output req, we, addr, wdata, wstrb,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, wstrb,
                    output gnt, rvalid, rdata);

endinterface
`default_nettype wire

// File: rtl/dcache_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : dcache_lane_align
// Brief   : Combinational lane steering. Store side replicates data across
//           byte lanes and builds strobes; load side extracts the addressed
//           byte/half and sign- or zero-extends it.
// Revision: 1.0 - initial release
// ============================================================================
module dcache_lane_align
    import dcache_access_ctrl_pkg::*;
(
    input  logic [1:0]          st_off,
    input  logic [2:0]          st_width,
    input  logic [c_data_w-1:0] st_wdata,
    output logic [c_data_w-1:0] al_wdata,
    output logic [3:0]          al_wstrb,
    input  logic [1:0]          ld_off,
    input  logic [2:0]          ld_width,
    input  logic                ld_sign,
    input  logic [c_data_w-1:0] ld_word,
    output logic [c_data_w-1:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store: replicate the LSB-justified datum to every lane, strobe the addressed one
    always_comb begin
        al_wdata = st_wdata;
        al_wstrb = 4'b1111;
        case (st_width)
            c_w_byte: begin
                al_wdata = {4{st_wdata[7:0]}};
                al_wstrb = 4'b0001 << st_off;
            end
            c_w_half: begin
                al_wdata = {2{st_wdata[15:0]}};
                al_wstrb = 4'b0011 << st_off;
            end
            default: begin
                al_wdata = st_wdata;
                al_wstrb = 4'b1111;
            end
        endcase
    end

    // Load: pick the addressed lane, then extend to a full word
    always_comb begin
        w_byte  = ld_word[{ld_off, 3'b000} +: 8];
        w_half  = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = ld_word;
        case (ld_width)
            c_w_byte: ld_data = {{24{ld_sign & w_byte[7]}}, w_byte};
            c_w_half: ld_data = {{16{ld_sign & w_half[15]}}, w_half};
            default:  ld_data = ld_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dcache_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dcache_access_ctrl
// Brief   : Sequences one MEM-stage data access per instruction onto a
//           single-port bus, stalling the pipeline until it completes.
//           Rejects misaligned/illegal accesses and aborts on timeout.
// Revision: 1.0 - initial release
// ============================================================================
module dcache_access_ctrl
    import dcache_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_ren,
    input  logic [2:0]           mem_rwidth,
    input  logic                 mem_rsign,
    input  logic                 mem_wen,
    input  logic [2:0]           mem_wwidth,
    input  logic [c_data_w-1:0]  mem_addr,
    input  logic [c_data_w-1:0]  mem_wdata,
    output logic                 stall,
    output logic [c_data_w-1:0]  rdata,
    output logic                 rdata_valid,
    output logic                 misalign,
    output logic                 acc_err,
    dcache_access_ctrl_if.master bus
);

    localparam int                  c_tmo_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_tmo_w-1:0]  c_tmo_last = c_tmo_w'(TIMEOUT_CYC - 1);

    logic [1:0]          r_state;
    logic [c_tmo_w-1:0]  r_tmo;
    logic                r_we;
    logic [c_data_w-1:0] r_addr;
    logic [c_data_w-1:0] r_wdata;
    logic [3:0]          r_wstrb;
    logic [1:0]          r_off;
    logic [2:0]          r_width;
    logic                r_sign;
    logic [c_data_w-1:0] r_rdata;
    logic                r_rdata_valid;
    logic                r_misalign;
    logic                r_acc_err;

    mem_op_e             w_op;
    logic [2:0]          w_width;
    logic                w_active;
    logic                w_legal;
    logic                w_aligned;
    logic                w_start;
    logic                w_tmo_hit;
    logic [c_data_w-1:0] w_al_wdata;
    logic [3:0]          w_al_wstrb;
    logic [c_data_w-1:0] w_ld_data;

    assign w_op      = mem_op(mem_ren, mem_wen);
    assign w_width   = mem_wen ? mem_wwidth : mem_rwidth;
    assign w_active  = mem_valid && (w_op != MEM_NONE);
    assign w_legal   = (w_op != MEM_ILLEGAL) && width_ok(w_width);
    assign w_aligned = is_aligned(w_width, mem_addr[1:0]);
    assign w_start   = w_active && w_legal && w_aligned;
    // >= rather than == so a grant on the last REQ cycle still bounds WAIT
    assign w_tmo_hit = (r_tmo >= c_tmo_last);

    // Store steering uses live inputs (latched in IDLE); load steering uses latched fields
    dcache_lane_align u_lane_align (
        .st_off   (mem_addr[1:0]),
        .st_width (w_width),
        .st_wdata (mem_wdata),
        .al_wdata (w_al_wdata),
        .al_wstrb (w_al_wstrb),
        .ld_off   (r_off),
        .ld_width (r_width),
        .ld_sign  (r_sign),
        .ld_word  (bus.rdata),
        .ld_data  (w_ld_data)
    );

    assign stall       = ((r_state == c_st_idle) && w_start) ||
                         (r_state == c_st_req) || (r_state == c_st_wait);
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign misalign    = r_misalign;
    assign acc_err     = r_acc_err;
    assign bus.req     = (r_state == c_st_req);
    assign bus.we      = r_we;
    assign bus.addr    = r_addr;
    assign bus.wdata   = r_wdata;
    assign bus.wstrb   = r_wstrb;

    // Access FSM, timeout counter and registered status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_tmo         <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= 4'b0000;
            r_off         <= 2'b00;
            r_width       <= 3'd0;
            r_sign        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_acc_err     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_acc_err     <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_we    <= mem_wen;
                        r_addr  <= {mem_addr[31:2], 2'b00};
                        r_wdata <= mem_wen ? w_al_wdata : '0;
                        r_wstrb <= mem_wen ? w_al_wstrb : 4'b0000;
                        r_off   <= mem_addr[1:0];
                        r_width <= w_width;
                        r_sign  <= mem_rsign;
                        r_tmo   <= '0;
                        r_state <= c_st_req;
                    end else if (w_active && !w_legal) begin
                        r_acc_err <= 1'b1;
                    end else if (w_active && !w_aligned) begin
                        r_misalign <= 1'b1;
                    end
                end
                c_st_req: begin
                    if (bus.gnt) begin
                        r_tmo   <= r_tmo + c_tmo_w'(1);
                        r_state <= r_we ? c_st_done : c_st_wait;
                    end else if (w_tmo_hit) begin
                        r_acc_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= c_st_done;
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end
                c_st_wait: begin
                    if (bus.rvalid) begin
                        r_rdata       <= w_ld_data;
                        r_rdata_valid <= 1'b1;
                        r_state       <= c_st_done;
                    end else if (w_tmo_hit) begin
                        r_acc_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= c_st_done;
                    end else begin
                        r_tmo <= r_tmo + c_tmo_w'(1);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_access_ctrl
// Brief   : Directed self-checking bench for dcache_access_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dcache_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ren, mem_rsign, mem_wen;
    logic [2:0]  mem_rwidth, mem_wwidth;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, rdata_valid, misalign, acc_err;
    logic [31:0] rdata;

    int n_vec = 0;
    int n_err = 0;

    dcache_access_ctrl_if bus ();

    dcache_access_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_ren     (mem_ren),
        .mem_rwidth  (mem_rwidth),
        .mem_rsign   (mem_rsign),
        .mem_wen     (mem_wen),
        .mem_wwidth  (mem_wwidth),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .acc_err     (acc_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access with grant on the first REQ cycle and read data on the next
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [2:0] width,
                        input logic sign, input logic [31:0] wdata, input logic [31:0] word,
                        input logic early_rv,
                        output logic [31:0] c_addr, output logic [31:0] c_wdata,
                        output logic [3:0] c_wstrb, output logic c_we,
                        output logic [31:0] c_rdata, output logic c_rv, output int n_stall);
        mem_valid = 1'b1; mem_ren = !we; mem_wen = we;
        mem_rwidth = width; mem_wwidth = width; mem_rsign = sign;
        mem_addr = addr; mem_wdata = wdata;
        #1 n_stall = int'(stall);
        tick();
        mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        c_addr = bus.addr; c_wdata = bus.wdata; c_wstrb = bus.wstrb; c_we = bus.we;
        n_stall += int'(stall);
        bus.gnt = 1'b1;
        if (early_rv) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hFFFF_FFFF;
        end
        tick();
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
        n_stall += int'(stall);
        if (!we) begin
            bus.rvalid = 1'b1;
            bus.rdata  = word;
            tick();
            bus.rvalid = 1'b0;
            n_stall += int'(stall);
        end
        c_rdata = rdata;
        c_rv    = rdata_valid;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, wd, rd;
        logic [3:0]  ws;
        logic        we, rv;
        int          ns, nreq;

        rst = 1'b1;
        mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_rsign = 1'b0;
        mem_rwidth = 3'd0; mem_wwidth = 3'd0; mem_addr = '0; mem_wdata = '0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, bus.req}, 32'd0);
        chk("rst_we", {31'd0, bus.we}, 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_wstrb", {28'd0, bus.wstrb}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rv", {31'd0, rdata_valid}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_err", {31'd0, acc_err}, 32'd0);
        rst = 1'b0;
        tick();

        // LW 0x100
        xfer(1'b0, 32'h100, 3'd4, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_rv", {31'd0, rv}, 32'd1);
        chk("lw_stall", ns, 32'd3);
        chk("lw_addr", a, 32'h100);
        chk("lw_we", {31'd0, we}, 32'd0);
        chk("lw_wstrb", {28'd0, ws}, 32'd0);
        chk("lw_rv_drop", {31'd0, rdata_valid}, 32'd0);

        // LB signed / unsigned at 0x103
        xfer(1'b0, 32'h103, 3'd1, 1'b1, 32'h0, 32'h8012_3456, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("lb_rdata", rd, 32'hFFFF_FF80);
        chk("lb_addr", a, 32'h100);
        xfer(1'b0, 32'h103, 3'd1, 1'b0, 32'h0, 32'h8012_3456, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("lbu_rdata", rd, 32'h0000_0080);

        // Halfword loads; the unsigned one also sees rvalid alongside gnt in REQ
        xfer(1'b0, 32'h102, 3'd2, 1'b1, 32'h0, 32'h8001_1234, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("lh_hi_rdata", rd, 32'hFFFF_8001);
        xfer(1'b0, 32'h100, 3'd2, 1'b0, 32'h0, 32'h1234_F00D, 1'b1, a, wd, ws, we, rd, rv, ns);
        chk("lhu_rdata", rd, 32'h0000_F00D);
        chk("lhu_stall", ns, 32'd3);
        xfer(1'b0, 32'h100, 3'd2, 1'b1, 32'h0, 32'hFFFF_7FFF, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("lh_pos_rdata", rd, 32'h0000_7FFF);

        // Stores
        xfer(1'b1, 32'h102, 3'd2, 1'b0, 32'h1234_ABCD, 32'h0, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("sh_wdata", wd, 32'hABCD_ABCD);
        chk("sh_wstrb", {28'd0, ws}, 32'hC);
        chk("sh_we", {31'd0, we}, 32'd1);
        chk("sh_stall", ns, 32'd2);
        chk("sh_addr", a, 32'h100);
        chk("sh_rv", {31'd0, rv}, 32'd0);
        xfer(1'b1, 32'h101, 3'd1, 1'b0, 32'h0000_00A5, 32'h0, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("sb_wdata", wd, 32'hA5A5_A5A5);
        chk("sb_wstrb", {28'd0, ws}, 32'h2);
        xfer(1'b1, 32'h204, 3'd4, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("sw_wdata", wd, 32'hCAFE_F00D);
        chk("sw_wstrb", {28'd0, ws}, 32'hF);
        chk("sw_addr", a, 32'h204);

        // Misaligned LW
        mem_valid = 1'b1; mem_ren = 1'b1; mem_rwidth = 3'd4; mem_addr = 32'h101;
        #1 chk("mis_stall", {31'd0, stall}, 32'd0);
        tick();
        mem_valid = 1'b0; mem_ren = 1'b0;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_req", {31'd0, bus.req}, 32'd0);
        chk("mis_err", {31'd0, acc_err}, 32'd0);
        tick();
        chk("mis_drop", {31'd0, misalign}, 32'd0);
        chk("mis_req2", {31'd0, bus.req}, 32'd0);

        // ren and wen together
        mem_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b1;
        mem_rwidth = 3'd4; mem_wwidth = 3'd4; mem_addr = 32'h100;
        #1 chk("rw_stall", {31'd0, stall}, 32'd0);
        tick();
        mem_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        chk("rw_err", {31'd0, acc_err}, 32'd1);
        chk("rw_req", {31'd0, bus.req}, 32'd0);
        tick();
        chk("rw_err_drop", {31'd0, acc_err}, 32'd0);

        // Width 3 is not a legal width
        mem_valid = 1'b1; mem_ren = 1'b1; mem_rwidth = 3'd3; mem_addr = 32'h100;
        #1 chk("w3_stall", {31'd0, stall}, 32'd0);
        tick();
        mem_valid = 1'b0; mem_ren = 1'b0;
        chk("w3_err", {31'd0, acc_err}, 32'd1);
        chk("w3_mis", {31'd0, misalign}, 32'd0);
        tick();

        // Timeout: never grant
        mem_valid = 1'b1; mem_ren = 1'b1; mem_rwidth = 3'd4; mem_addr = 32'h300;
        tick();
        mem_valid = 1'b0; mem_ren = 1'b0;
        nreq = 0;
        while (bus.req && nreq < 10) begin
            nreq++;
            tick();
        end
        chk("tmo_req_cycles", nreq, 32'd4);
        chk("tmo_err", {31'd0, acc_err}, 32'd1);
        chk("tmo_rv", {31'd0, rdata_valid}, 32'd0);
        chk("tmo_rdata", rdata, 32'd0);
        chk("tmo_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("tmo_err_drop", {31'd0, acc_err}, 32'd0);
        chk("tmo_req_idle", {31'd0, bus.req}, 32'd0);

        // Reset while waiting for read data
        mem_valid = 1'b1; mem_ren = 1'b1; mem_rwidth = 3'd4; mem_addr = 32'h400;
        tick();
        mem_valid = 1'b0; mem_ren = 1'b0;
        bus.gnt = 1'b1;
        tick();
        bus.gnt = 1'b0;
        chk("rw8_wait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstw_req", {31'd0, bus.req}, 32'd0);
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 32'h1111_1111;
        tick();
        bus.rvalid = 1'b0;
        chk("rstw_rv", {31'd0, rdata_valid}, 32'd0);
        chk("rstw_rdata", rdata, 32'd0);
        tick();
        chk("rstw_rv2", {31'd0, rdata_valid}, 32'd0);
        xfer(1'b0, 32'h500, 3'd4, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, a, wd, ws, we, rd, rv, ns);
        chk("post_rst_rdata", rd, 32'h0BAD_F00D);
        chk("post_rst_stall", ns, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
